// File: rtl/add_slice_seq.sv
// add_slice_seq: WIDTH-bit add/sub by walking one shared SLICE-bit adder LSB slice first
module add_slice_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [SLICE-1:0] sl_a,
    output logic [SLICE-1:0] sl_b,
    output logic             sl_cin,
    input  logic [SLICE-1:0] sl_sum,
    input  logic             sl_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = $clog2(NSLICE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           carry_q, carry_d;
    logic                           cout_q, cout_d;
    logic                           ovf_q, ovf_d;
    logic [NSLICE-1:0][SLICE-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                           run, last;

    assign run       = state_q == RUN;
    assign last      = idx_q == IW'(NSLICE - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sl_a      = run ? a_q[idx_q] : '0;
    assign sl_b      = run ? b_q[idx_q] : '0;
    assign sl_cin    = run & carry_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    // next state: latch operands on accept, fold one adder slice per RUN cycle, hold result in DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_sub ? ~in_b : in_b;
                carry_d = in_sub;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q] = sl_sum;
                carry_d      = sl_cout;
                idx_d        = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[NSLICE-1][SLICE-1] == b_q[NSLICE-1][SLICE-1]) &&
                              (sl_sum[SLICE-1] != a_q[NSLICE-1][SLICE-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: tb/tb_add_slice_seq.sv
// tb_add_slice_seq: directed vector table plus handshake, backpressure and reset sequences
module tb_add_slice_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b, out_sum;
    logic [7:0]  sl_a, sl_b, sl_sum;
    logic        sl_cin, sl_cout, out_valid, out_ready, out_cout, out_ovf;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    assign {sl_cout, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {8'd0, sl_cin};

    add_slice_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_sum(sl_sum), .sl_cout(sl_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic sub);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume;
        chk("ready_in_done", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
        chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vt[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[9] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_sum", out_sum, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_sum", out_sum, 32'd0);
        end
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("run0_cin", {31'd0, sl_cin}, 32'd0);
        chk("run0_sl_a", {24'd0, sl_a}, 32'hFF);
        tick();
        chk("run1_cin", {31'd0, sl_cin}, 32'd1);
        chk("run1_valid", {31'd0, out_valid}, 32'd0);
        wait_done(lat);
        chk("chain_latency", lat + 1, 32'd5);
        chk("chain_sum", out_sum, 32'h0000_0100);
        consume();
        for (int i = 0; i < 10; i++) begin
            accept(vt[i].a, vt[i].b, vt[i].sub);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd5);
            chk($sformatf("v%0d_sum", i), out_sum, vt[i].s);
            chk($sformatf("v%0d_cout", i), {31'd0, out_cout}, {31'd0, vt[i].c});
            chk($sformatf("v%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vt[i].o});
            consume();
        end
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat);
        chk("bp_latency", lat, 32'd5);
        for (int i = 0; i < 6; i++) begin
            in_a = 32'hDEAD_0000 + i;
            in_b = 32'h0BAD_F00D;
            in_sub = i[0];
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", out_sum, 32'h8000_0000);
            chk("bp_ovf", {31'd0, out_ovf}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        consume();
        accept(32'h1234_5678, 32'h1111_1111, 1'b0);
        tick();
        tick();
        chk("mid_sl_a", {24'd0, sl_a}, 32'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        accept(32'd3, 32'd4, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", lat, 32'd5);
        chk("post_rst_sum", out_sum, 32'd7);
        chk("post_rst_cout", {31'd0, out_cout}, 32'd0);
        consume();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
